// File: rtl/noc_link_rx.sv
`default_nettype none
// ============================================================================
// Module   : noc_link_rx
// Purpose  : Receive side of a credit-flow-controlled NoC link. Checks
//            head/tail framing, buffers accepted flits in a first-word-fall-
//            through FIFO, returns credits upstream. Define
//            NOC_LINK_RX_ERR_CNT_EN to add the saturating err_cnt output.
// Revision : 1.0
// ============================================================================
module noc_link_rx #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              link_valid,
    input  logic [FLIT_W-1:0] link_flit,
    input  logic              link_head,
    input  logic              link_tail,
    output logic [1:0]        credit_ret,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_head,
    output logic              out_tail,
    output logic              err_frame,
    output logic              err_ovf
`ifdef NOC_LINK_RX_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    count_q, count_d;
    logic [1:0]        credit_q, credit_d;
    logic              err_frame_q, err_ovf_q;

    logic [FLIT_W-1:0] mem_flit_q [DEPTH];
    logic [DEPTH-1:0]  mem_head_q;
    logic [DEPTH-1:0]  mem_tail_q;

    logic full, empty, pop, push, frame_drop, ovf_drop;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign pop      = !empty && out_ready;
    // Overflow is judged before this cycle's pop, so a drain never rescues the flit.
    assign ovf_drop = link_valid && full;

    always_comb begin
        state_d    = state_q;
        push       = 1'b0;
        frame_drop = 1'b0;
        if (link_valid && !full) begin
            case (state_q)
                ST_IDLE: begin
                    if (link_head) begin
                        push = 1'b1;
                        if (!link_tail) state_d = ST_BODY;
                    end else begin
                        frame_drop = 1'b1;
                    end
                end
                ST_BODY: begin
                    if (link_head) begin
                        frame_drop = 1'b1;
                    end else begin
                        push = 1'b1;
                        if (link_tail) state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        count_d  = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        // Framing drops consumed an upstream credit, so they are refunded too.
        credit_d = {1'b0, pop} + {1'b0, frame_drop};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            credit_q    <= '0;
            err_frame_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            credit_q <= credit_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (frame_drop) err_frame_q <= 1'b1;
            if (ovf_drop)   err_ovf_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_flit_q[wr_ptr_q] <= link_flit;
            mem_head_q[wr_ptr_q] <= link_head;
            mem_tail_q[wr_ptr_q] <= link_tail;
        end
    end

    assign out_valid  = !empty;
    assign out_flit   = empty ? '0   : mem_flit_q[rd_ptr_q];
    assign out_head   = empty ? 1'b0 : mem_head_q[rd_ptr_q];
    assign out_tail   = empty ? 1'b0 : mem_tail_q[rd_ptr_q];
    assign credit_ret = credit_q;
    assign err_frame  = err_frame_q;
    assign err_ovf    = err_ovf_q;

`ifdef NOC_LINK_RX_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else if ((frame_drop || ovf_drop) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_link_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_link_rx
// Purpose  : Self-checking bench for noc_link_rx against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_noc_link_rx;

    localparam int FLIT_W = 32;
    localparam int DEPTH  = 4;
`ifdef NOC_LINK_RX_ERR_CNT_EN
    localparam int VW = FLIT_W + 7 + 8;
`else
    localparam int VW = FLIT_W + 7;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              link_valid = 1'b0;
    logic [FLIT_W-1:0] link_flit = '0;
    logic              link_head = 1'b0;
    logic              link_tail = 1'b0;
    logic              out_ready = 1'b0;
    logic [1:0]        credit_ret;
    logic              out_valid;
    logic [FLIT_W-1:0] out_flit;
    logic              out_head;
    logic              out_tail;
    logic              err_frame;
    logic              err_ovf;
`ifdef NOC_LINK_RX_ERR_CNT_EN
    logic [7:0]        err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    noc_link_rx #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .link_valid (link_valid),
        .link_flit  (link_flit),
        .link_head  (link_head),
        .link_tail  (link_tail),
        .credit_ret (credit_ret),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_flit   (out_flit),
        .out_head   (out_head),
        .out_tail   (out_tail),
        .err_frame  (err_frame),
        .err_ovf    (err_ovf)
`ifdef NOC_LINK_RX_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: buffered packets as a queue of {head, tail, flit}
    logic [FLIT_W+1:0] m_q[$];
    logic              m_body;
    logic              m_eframe;
    logic              m_eovf;
    logic [1:0]        m_credit;
    int                m_cnt;

    task automatic model_reset();
        m_q.delete();
        m_body   = 1'b0;
        m_eframe = 1'b0;
        m_eovf   = 1'b0;
        m_credit = 2'd0;
        m_cnt    = 0;
    endtask

    task automatic model_step(input logic v, input logic [FLIT_W-1:0] f,
                              input logic h, input logic t, input logic r);
        int  pops;
        int  drops;
        logic do_push;
        pops    = (m_q.size() > 0 && r) ? 1 : 0;
        drops   = 0;
        do_push = 1'b0;
        if (v) begin
            if (m_q.size() == DEPTH) begin
                m_eovf = 1'b1;
                m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
            end else if ((!m_body && !h) || (m_body && h)) begin
                m_eframe = 1'b1;
                drops    = 1;
                m_cnt    = (m_cnt < 255) ? m_cnt + 1 : 255;
            end else begin
                do_push = 1'b1;
                if (!m_body && !t) m_body = 1'b1;
                else if (m_body && t) m_body = 1'b0;
            end
        end
        if (pops == 1) void'(m_q.pop_front());
        if (do_push) m_q.push_back({h, t, f});
        m_credit = 2'(pops + drops);
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [FLIT_W+1:0] hd;
        logic              v;
        v  = (m_q.size() != 0);
        hd = v ? m_q[0] : '0;
`ifdef NOC_LINK_RX_ERR_CNT_EN
        return {v, hd[FLIT_W+1], hd[FLIT_W], hd[FLIT_W-1:0], m_credit, m_eframe, m_eovf, 8'(m_cnt)};
`else
        return {v, hd[FLIT_W+1], hd[FLIT_W], hd[FLIT_W-1:0], m_credit, m_eframe, m_eovf};
`endif
    endfunction

    function automatic logic [VW-1:0] obs_vec();
`ifdef NOC_LINK_RX_ERR_CNT_EN
        return {out_valid, out_head, out_tail, out_flit, credit_ret, err_frame, err_ovf, err_cnt};
`else
        return {out_valid, out_head, out_tail, out_flit, credit_ret, err_frame, err_ovf};
`endif
    endfunction

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic drive(input logic v, input logic [FLIT_W-1:0] f,
                         input logic h, input logic t, input logic r);
        link_valid = v;
        link_flit  = f;
        link_head  = h;
        link_tail  = t;
        out_ready  = r;
        model_step(v, f, h, t, r);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        link_valid = 1'b0; link_flit = '0; link_head = 1'b0; link_tail = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", obs_vec());
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== '0 || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL idle_after_reset[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_packet();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), (i == 0), (i == 2), 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL pkt_model[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (out_flit !== 32'hA0 + 32'(i) || out_head !== (i == 0) || out_tail !== (i == 2)
                || credit_ret !== ((i == 0) ? 2'd0 : 2'd1)) begin
                errors++;
                $display("FAIL pkt_flit[%0d]: got flit=%h h=%b t=%b cr=%0d want flit=%h cr=%0d",
                         i, out_flit, out_head, out_tail, credit_ret, 32'hA0 + 32'(i), (i == 0) ? 0 : 1);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (credit_ret !== 2'd1 || out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL pkt_last_credit: got cr=%0d v=%b want cr=1 v=0", credit_ret, out_valid);
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (credit_ret !== 2'd0) begin
            errors++;
            $display("FAIL pkt_credit_idle: got %0d want 0", credit_ret);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hC0 + 32'(i), 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec() || credit_ret !== 2'd0 || err_ovf !== (i == 4)) begin
                errors++;
                $display("FAIL ovf_fill[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec() || credit_ret !== 2'd1 || err_ovf !== 1'b1
                || (i < 3 && out_flit !== 32'hC1 + 32'(i)) || (i == 3 && out_valid !== 1'b0)) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_framing();
        do_reset();
        drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
        checks++;
        if (err_frame !== 1'b1 || credit_ret !== 2'd1 || out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL frame_body_idle: got %h want %h", obs_vec(), exp_vec());
        end
        drive(1'b1, 32'h10, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'h11, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || credit_ret !== 2'd2 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL frame_head_in_body: got %h want %h", obs_vec(), exp_vec());
        end
        drive(1'b1, 32'h12, 1'b0, 1'b1, 1'b1);
        checks++;
        if (out_flit !== 32'h12 || out_tail !== 1'b1 || out_head !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL frame_tail_accept: got %h want %h", obs_vec(), exp_vec());
        end
`ifdef NOC_LINK_RX_ERR_CNT_EN
        checks++;
        if (err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL frame_err_cnt: got %0d want 2", err_cnt);
        end
`endif
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_pop_drop();
        drive(1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 32'h41, 1'b0, 1'b0, 1'b1);
        checks++;
        if (credit_ret !== 2'd2 || out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL pop_and_drop: got cr=%0d vec=%h want cr=2 vec=%h", credit_ret, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h20, 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_flit !== 32'h20 || out_head !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL arst_pre: got %h want %h", obs_vec(), exp_vec());
        end
        link_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== '0) begin
            errors++;
            $display("FAIL arst_immediate: got %h want 0", obs_vec());
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 32'h30, 1'b1, 1'b1, 1'b1);
        checks++;
        if (out_flit !== 32'h30 || out_head !== 1'b1 || out_tail !== 1'b1 || err_frame !== 1'b0
            || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL arst_recover: got %h want %h", obs_vec(), exp_vec());
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (credit_ret !== 2'd1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL arst_credit: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic v, h, t, r;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 7) == 0) begin
                h = 1'($urandom);
                t = 1'($urandom);
            end else if (!m_body) begin
                h = 1'b1;
                t = 1'($urandom);
            end else begin
                h = 1'b0;
                t = ($urandom_range(0, 2) == 0);
            end
            drive(v, $urandom, h, t, r);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_packet();
        test_overflow();
        test_framing();
        test_pop_drop();
        test_async_reset();
        do_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_link_rx.md
Name: noc_link_rx

Overview:
- Receiving end of a credit-flow-controlled NoC link, at the input of a router port or network interface.
- Accepts flits, checks head/tail framing, and buffers accepted flits in a small first-word-fall-through FIFO.
- Presents buffered flits downstream with a valid/ready handshake.
- Returns one credit upstream for every buffer slot the upstream sender has given up.

Parameters:
FLIT_W, 32, flit payload width in bits
DEPTH, 4, FIFO entries; equals the initial credit count held by the upstream sender; power of two, minimum 2
PTR_W, 2, log2(DEPTH); the integrator sets it consistent with DEPTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
link_valid  input  1  flit present on the link this cycle
link_flit  input  FLIT_W  flit payload
link_head  input  1  first flit of a packet
link_tail  input  1  last flit of a packet
credit_ret  output  2  number of credits returned upstream this cycle (0..2)
out_valid  output  1  FIFO non-empty
out_ready  input  1  downstream accepts out_* this cycle
out_flit  output  FLIT_W  FIFO head payload
out_head  output  1  FIFO head head-flag
out_tail  output  1  FIFO head tail-flag
err_frame  output  1  sticky framing-error flag
err_ovf  output  1  sticky overflow flag

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, pointers 0, count 0, FSM=IDLE, credit_ret=0, out_valid=0, out_flit/out_head/out_tail=0, err_frame=0, err_ovf=0. Deassertion is synchronised outside this block.
- Reset mid-packet: partial packet discarded, FSM=IDLE. The upstream sender resets its credits to DEPTH in the same reset domain.
- Storage: DEPTH entries of {head, tail, flit}. out_* are driven from the entry at the read pointer.
- out_flit/out_head/out_tail are 0 when the FIFO is empty.
- pop = out_valid & out_ready.
- Full is judged on the registered count at the clock edge, before that cycle's pop.
- Overflow: link_valid while count==DEPTH.
  - Flit dropped, err_ovf set, no credit returned.
  - This holds even if a pop occurs in the same cycle.
- Framing FSM, evaluated only on flits that are not overflow drops:
  - IDLE, head=1 tail=1: push, stay IDLE (single-flit packet).
  - IDLE, head=1 tail=0: push, go to BODY.
  - IDLE, head=0: flit dropped, err_frame set, stay IDLE.
  - BODY, head=0 tail=0: push, stay BODY.
  - BODY, head=0 tail=1: push, go to IDLE.
  - BODY, head=1: flit dropped, err_frame set, stay BODY.
- Framing-dropped flits consumed an upstream credit, so each one returns one credit.
- credit_ret is registered. Its value at cycle N+1 = (pop at N) + (framing drop at N), giving a range of 0..2.
- Latency: a flit pushed at edge N is visible on out_* from cycle N+1 if the FIFO was empty at N. Otherwise it follows FIFO order.
- Simultaneous push and pop when not full: both occur, count unchanged.
- Pointers wrap modulo DEPTH. Count is PTR_W+1 bits.
- err_frame and err_ovf clear only on reset.

Optional Feature:
- Macro NOC_LINK_RX_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt [7:0], reset 0.
  - Increments by 1 for each framing drop and each overflow drop.
  - Saturates at 255.
  - Only one drop can occur per cycle, so the increment is at most 1.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, release, no traffic -> all outputs 0, out_valid=0, credit_ret=0 indefinitely.
- 3-flit packet with out_ready=1. Input H(0xA0), B(0xA1), T(0xA2) on consecutive cycles from cycle 0 -> out_flit 0xA0/0xA1/0xA2 at cycles 1/2/3 with correct head/tail flags; credit_ret=1 at cycles 2/3/4.
- Fill and overflow with out_ready=0, DEPTH=4. Send 4 single-flit packets, then a 5th -> out_valid=1, 5th dropped, err_ovf=1, credit_ret stays 0. Then raise out_ready -> 4 flits drain in order, credit_ret=1 for four cycles.
- Framing errors:
  - Body flit 0x55 while IDLE -> dropped, err_frame=1, credit_ret=1 next cycle.
  - Head 0x10, then head 0x11 -> 0x11 dropped, FSM stays BODY; a following tail 0x12 is accepted.
  - With the feature macro defined, err_cnt=2.
- Pop plus framing drop in the same cycle: FIFO holds 1 flit, out_ready=1, illegal body flit while IDLE -> credit_ret=2 on the next cycle.
- Asynchronous reset mid-packet: assert rst between clock edges after head 0x20 is pushed -> outputs go to 0 immediately without a clock edge; after release, a new single-flit packet 0x30 is delivered normally.
